lcd_bus_writer: RTL
===================

LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

Interface
REQ-001 SHALL have parameter T_SETUP, 3, cycles RS/RW/data are stable before EN rises.
REQ-002 SHALL have parameter T_EN, 13, cycles EN is held high.
REQ-003 SHALL have parameter T_HOLD, 2, cycles RS/RW/data are held after EN falls.
REQ-004 SHALL have parameter T_EXEC, 2000, cycles waited after a normal command or data write.
REQ-005 SHALL have parameter T_CLEAR, 82000, cycles waited after a clear command (i_LCD_CL=1).
REQ-006 SHALL have port i_clk  input  1  system clock; all logic is on its rising edge.
REQ-007 SHALL have port i_rst_n  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_start  input  1  single-cycle request to issue one LCD transfer.
REQ-009 SHALL have port i_LCD_data  input  8  byte to place on the LCD bus.
REQ-010 SHALL have port i_LCD_RS  input  1  register select (0 = instruction, 1 = data).
REQ-011 SHALL have port i_LCD_RW  input  1  read/write select, passed to the bus unchanged.
REQ-012 SHALL have port i_LCD_CL  input  1  marks the transfer as a clear/home command needing the long wait.
REQ-013 SHALL have port o_LCD_data  output  8  LCD data bus.
REQ-014 SHALL have port o_LCD_EN  output  1  LCD enable strobe.
REQ-015 SHALL have port o_LCD_RS  output  1  LCD register select.
REQ-016 SHALL have port o_LCD_RW  output  1  LCD read/write.
REQ-017 SHALL have port o_busy  output  1  high from the accepted start until o_write_fin.
REQ-018 SHALL have port o_write_fin  output  1  one-cycle pulse when the transfer and its execution wait are complete.

Function
REQ-019 SHALL implement the states S_IDLE, S_SETUP, S_EN, S_HOLD, S_WAIT and S_DONE.
REQ-020 SHALL, in S_IDLE with i_start=1, latch data/RS/RW/CL into registers, clear the counter, and enter S_SETUP on the next edge.
REQ-021 SHALL ignore i_start in every state except S_IDLE; the latched values SHALL NOT change during a transfer.
REQ-022 SHALL drive o_LCD_data, o_LCD_RS and o_LCD_RW from the latched registers in every state from S_SETUP through S_WAIT.
REQ-023 SHALL keep o_LCD_EN=0 for exactly T_SETUP cycles in S_SETUP, then move to S_EN.
REQ-024 SHALL drive o_LCD_EN=1 for exactly T_EN consecutive cycles in S_EN, then move to S_HOLD.
REQ-025 SHALL keep o_LCD_EN=0 for exactly T_HOLD cycles in S_HOLD, then move to S_WAIT.
REQ-026 SHALL stay in S_WAIT for T_CLEAR cycles when the latched CL=1, otherwise for T_EXEC cycles, then move to S_DONE.
REQ-027 SHALL assert o_write_fin for exactly one cycle in S_DONE, then return to S_IDLE.
REQ-028 SHALL drive o_LCD_EN from a register, with no combinational path from any input.
REQ-029 SHALL make o_busy combinational: high whenever the state is not S_IDLE, including S_DONE.
REQ-030 SHALL size a single shared down-counter to hold the maximum of all timing parameters (17 bits at the defaults); the counter SHALL NOT wrap within a state.
REQ-031 SHALL accept an i_start arriving in the S_IDLE cycle directly after S_DONE, so back-to-back transfers are possible.
REQ-032 SHALL hold o_LCD_data, o_LCD_RS and o_LCD_RW at the last latched values while in S_IDLE.
REQ-033 SHALL treat any parameter value of 0 as 1 cycle.

Reset
REQ-034 SHALL, while i_rst_n=1 (asynchronously, in any state including mid-transfer), set the state to S_IDLE and the counter to 0.
REQ-035 SHALL, during reset, set o_LCD_data=8'h00, o_LCD_EN=0, o_LCD_RS=0, o_LCD_RW=0, o_busy=0 and o_write_fin=0.
REQ-036 SHALL NOT produce an o_write_fin pulse for a transfer that reset aborted.

Structure
REQ-037 SHALL take the state enum and the default timing constants from a shared package, lcd_pkg, which the initializer and the top level also use.
REQ-038 SHALL be a single module with no sub-modules.

Verification
REQ-039 SHALL verify a data write: start with data=8'h41, RS=1, RW=0, CL=0 -> EN high for 13 cycles beginning 4 cycles after start, bus=8'h41 with RS=1, o_write_fin 3+13+2+2000+1 cycles after start.
REQ-040 SHALL verify a clear: start with data=8'h01, RS=0, CL=1 -> o_write_fin 82019 cycles after start, o_busy=1 for that whole span.
REQ-041 SHALL verify start ignored while busy: a second start with data=8'h55 during S_EN -> the bus keeps the first byte, exactly one o_write_fin.
REQ-042 SHALL verify back-to-back transfers: start on the cycle after o_write_fin -> a second transfer begins, EN pulses are separated by exactly T_HOLD+T_EXEC+1+1+T_SETUP cycles.
REQ-043 SHALL verify reset mid-transfer: assert i_rst_n during S_WAIT -> outputs go to reset values immediately, no o_write_fin, and a new start after release completes normally.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg : shared LCD bus state encoding, default timings and sizing helpers
// Revision : 1.0
// ============================================================================
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EN    = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } lcd_state_e;

  localparam int unsigned LCD_T_SETUP = 3;
  localparam int unsigned LCD_T_EN    = 13;
  localparam int unsigned LCD_T_HOLD  = 2;
  localparam int unsigned LCD_T_EXEC  = 2000;
  localparam int unsigned LCD_T_CLEAR = 82000;

  // A zero-length phase would be meaningless on the bus, so it becomes one cycle.
  function automatic int unsigned lcd_eff(input int unsigned t);
    return (t == 0) ? 1 : t;
  endfunction

  // Counter holds (duration - 1), so it needs clog2 of the longest duration.
  function automatic int unsigned lcd_cnt_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d,
                                                input int unsigned e);
    int unsigned m;
    m = lcd_eff(a);
    if (lcd_eff(b) > m) m = lcd_eff(b);
    if (lcd_eff(c) > m) m = lcd_eff(c);
    if (lcd_eff(d) > m) m = lcd_eff(d);
    if (lcd_eff(e) > m) m = lcd_eff(e);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_bus_writer.sv
`default_nettype none
// ============================================================================
// lcd_bus_writer : issues one HD44780-style bus write (setup/EN/hold/exec wait)
// Revision : 1.0
// ============================================================================
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = LCD_T_SETUP,
  parameter int unsigned T_EN    = LCD_T_EN,
  parameter int unsigned T_HOLD  = LCD_T_HOLD,
  parameter int unsigned T_EXEC  = LCD_T_EXEC,
  parameter int unsigned T_CLEAR = LCD_T_CLEAR
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_LCD_data,
  input  logic       i_LCD_RS,
  input  logic       i_LCD_RW,
  input  logic       i_LCD_CL,
  output logic [7:0] o_LCD_data,
  output logic       o_LCD_EN,
  output logic       o_LCD_RS,
  output logic       o_LCD_RW,
  output logic       o_busy,
  output logic       o_write_fin
);

  localparam int unsigned CNT_W = lcd_cnt_width(T_SETUP, T_EN, T_HOLD, T_EXEC, T_CLEAR);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(lcd_eff(T_SETUP) - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(lcd_eff(T_EN) - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(lcd_eff(T_HOLD) - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(lcd_eff(T_EXEC) - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(lcd_eff(T_CLEAR) - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic             cl_q, cl_d;
  logic             en_q, en_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Each phase loads (length - 1) on entry and advances when the count reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    cl_d    = cl_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          data_d  = i_LCD_data;
          rs_d    = i_LCD_RS;
          rw_d    = i_LCD_RW;
          cl_d    = i_LCD_CL;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_EN;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EN: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_WAIT;
          cnt_d   = cl_q ? CLEAR_LD : EXEC_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // EN is registered off the next state so it lines up exactly with S_EN.
    en_d = (state_d == S_EN);
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      cl_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      cl_q    <= cl_d;
      en_q    <= en_d;
    end
  end

  assign o_LCD_data  = data_q;
  assign o_LCD_RS    = rs_q;
  assign o_LCD_RW    = rw_q;
  assign o_LCD_EN    = en_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_write_fin = (state_q == S_DONE);

endmodule : lcd_bus_writer
`default_nettype wire
